// File: rtl/vga_timing.sv
//------------------------------------------------------------------------------
// vga_timing
//
// Raster timing generator for the Pac-Man VGA path (640x480 @ 60 Hz by
// default). It produces the pixel-clock enable, the raw horizontal/vertical
// counters, the visible-area flag, the active-low sync pulses and one-clk
// line/frame start strobes. The sync pins are driven from here, and the
// renderers register colour on pix_en using the x/y/active values present in
// that same cycle.
//
// Build option:
//   VGA_PIX_DIV_EN  defined   -> clk is 50 MHz; pix_en toggles every clk, so
//                                one pixel step takes two clk.
//                   undefined -> clk is already the 25 MHz pixel clock; pix_en
//                                is 1 on every clk once out of reset.
//
// Geometry parameters: H_ACTIVE/H_FP/H_SYNC/H_BP (pixels) and
// V_ACTIVE/V_FP/V_SYNC/V_BP (lines). Their sums H_TOTAL and V_TOTAL must not
// exceed 1024, since the counters are 10 bits wide.
//
// Ports:
//   clk          in   system clock, the only clock
//   rst          in   synchronous, active-high reset
//   pix_en       out  pixel-clock enable, one pixel step per high cycle
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   active       out  high while (x,y) lies in the visible area
//   x            out  horizontal count, 0..H_TOTAL-1
//   y            out  vertical count, 0..V_TOTAL-1
//   line_start   out  one-clk pulse after the edge that loads x = 0
//   frame_start  out  one-clk pulse after the edge that loads (x,y) = (0,0)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries held at counter width so every compare is 10 bits.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       active_next;

  // Counter value the next pixel step will load, and its decodes. The output
  // registers are loaded from these so they change on the same edge as x/y.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    x_next = x + 10'd1;
    y_next = y;
    if (x == H_LAST) begin
      x_next = '0;
      y_next = (y == V_LAST) ? '0 : y + 10'd1;
    end
    hsync_next  = !((x_next >= HS_START) && (x_next < HS_END));
    vsync_next  = !((y_next >= VS_START) && (y_next < VS_END));
    active_next = (x_next < H_VIS) && (y_next < V_VIS);
  end

  // Reset parks the counters on the last pixel of the frame, so the first
  // pixel step after reset lands on (0,0) and raises frame_start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      pix_en      <= 1'b0;
      x           <= H_LAST;
      y           <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
`ifdef VGA_PIX_DIV_EN
      pix_en <= ~pix_en;
`else
      pix_en <= 1'b1;
`endif
      // Strobes last one clk even when a pixel step spans two clk.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        x           <= x_next;
        y           <= y_next;
        hsync       <= hsync_next;
        vsync       <= vsync_next;
        active      <= active_next;
        line_start  <= (x_next == '0);
        frame_start <= (x_next == '0) && (y_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
//------------------------------------------------------------------------------
// tb_vga_timing
//
// Drives two vga_timing instances from one clock and reset: one with the
// standard 640x480 geometry and one with a small geometry so whole frames fit
// in a short run. A behavioural model tracks the number of pixel steps taken
// since reset and derives the expected raster position and decodes from it
// with plain division/modulo arithmetic.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_timing;

  typedef struct {
    int ht; int vt;
    int ha; int hf; int hs;
    int va; int vf; int vs;
  } geom_t;

`ifdef VGA_PIX_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  // Small geometry: 20+4+6+5 = 35 pixels per line, 12+2+3+2 = 19 lines.
  localparam int S_FRAME = 35 * 19;

  geom_t g_full  = '{ht: 800, vt: 525, ha: 640, hf: 16, hs: 96, va: 480, vf: 10, vs: 2};
  geom_t g_small = '{ht: 35,  vt: 19,  ha: 20,  hf: 4,  hs: 6,  va: 12,  vf: 2,  vs: 3};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       f_pix, f_hsync, f_vsync, f_active, f_ls, f_fs;
  logic [9:0] f_x, f_y;
  logic       s_pix, s_hsync, s_vsync, s_active, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [25:0] f_vec, s_vec;

  assign f_vec = {f_pix, f_hsync, f_vsync, f_active, f_ls, f_fs, f_x, f_y};
  assign s_vec = {s_pix, s_hsync, s_vsync, s_active, s_ls, s_fs, s_x, s_y};

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pixel steps since reset, model pix_en, and whether the last
  // edge performed a step.
  int steps     = 0;
  bit m_pix     = 1'b0;
  bit m_stepped = 1'b0;

  always #5 clk = ~clk;

  vga_timing dut_full (
    .clk(clk), .rst(rst), .pix_en(f_pix), .hsync(f_hsync), .vsync(f_vsync),
    .active(f_active), .x(f_x), .y(f_y), .line_start(f_ls), .frame_start(f_fs)
  );

  vga_timing #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(2)
  ) dut_small (
    .clk(clk), .rst(rst), .pix_en(s_pix), .hsync(s_hsync), .vsync(s_vsync),
    .active(s_active), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  // Expected output vector for a geometry, from the step count alone.
  function automatic logic [25:0] expect_vec(input geom_t g);
    int n, xx, yy;
    logic hs, vs, act, ls, fs;
    if (steps == 0) begin
      xx = g.ht - 1; yy = g.vt - 1;
      hs = 1'b1; vs = 1'b1; act = 1'b0; ls = 1'b0; fs = 1'b0;
    end else begin
      n   = steps - 1;
      xx  = n % g.ht;
      yy  = (n / g.ht) % g.vt;
      hs  = !((xx >= g.ha + g.hf) && (xx < g.ha + g.hf + g.hs));
      vs  = !((yy >= g.va + g.vf) && (yy < g.va + g.vf + g.vs));
      act = (xx < g.ha) && (yy < g.va);
      ls  = m_stepped && (xx == 0);
      fs  = ls && (yy == 0);
    end
    return {m_pix, hs, vs, act, ls, fs, xx[9:0], yy[9:0]};
  endfunction

  // Advance one clk; the model sees the same rst the DUTs sample. Returns
  // 1 ns after the edge, where outputs are settled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      steps = 0; m_pix = 1'b0; m_stepped = 1'b0;
    end else begin
      m_stepped = m_pix;
      if (m_pix) steps++;
      m_pix = (DIV == 2) ? !m_pix : 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] got [10];
    int         want [10];
    string      name [10];
    rst = 1'b1;
    repeat (5) tick();
    got[0] = f_x;               want[0] = 799; name[0] = "reset_x";
    got[1] = f_y;               want[1] = 524; name[1] = "reset_y";
    got[2] = {9'd0, f_hsync};   want[2] = 1;   name[2] = "reset_hsync";
    got[3] = {9'd0, f_vsync};   want[3] = 1;   name[3] = "reset_vsync";
    got[4] = {9'd0, f_active};  want[4] = 0;   name[4] = "reset_active";
    got[5] = {9'd0, f_pix};     want[5] = 0;   name[5] = "reset_pix_en";
    got[6] = {9'd0, f_ls};      want[6] = 0;   name[6] = "reset_line_start";
    got[7] = {9'd0, f_fs};      want[7] = 0;   name[7] = "reset_frame_start";
    got[8] = s_x;               want[8] = 34;  name[8] = "reset_small_x";
    got[9] = s_y;               want[9] = 18;  name[9] = "reset_small_y";
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (got[i] !== 10'(want[i])) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", name[i], got[i], want[i]);
      end
    end
  endtask

  task automatic test_release();
    int fs_at = -1;
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_checks += 2;
      if (f_vec !== expect_vec(g_full)) begin
        n_fail++;
        $display("FAIL release_full: got %h expected %h (cycle %0d)", f_vec, expect_vec(g_full), c);
      end
      if (s_vec !== expect_vec(g_small)) begin
        n_fail++;
        $display("FAIL release_small: got %h expected %h (cycle %0d)", s_vec, expect_vec(g_small), c);
      end
      if (f_fs === 1'b1 && fs_at < 0) fs_at = c;
    end
    n_checks++;
    if (fs_at != 2) begin
      n_fail++;
      $display("FAIL frame_start_latency: got %0d clk expected 2 clk", fs_at);
    end
  endtask

  task automatic test_line();
    int   fall_at = -1, last_ls = -1;
    logic prev_hs = f_hsync;
    logic prev_act = f_active;
    for (int c = 0; c < 1700 * DIV; c++) begin
      tick();
      n_checks += 2;
      if (f_vec !== expect_vec(g_full)) begin
        n_fail++;
        $display("FAIL line_full: got %h expected %h (steps %0d)", f_vec, expect_vec(g_full), steps);
      end
      if (s_vec !== expect_vec(g_small)) begin
        n_fail++;
        $display("FAIL line_small: got %h expected %h (steps %0d)", s_vec, expect_vec(g_small), steps);
      end
      if (prev_hs === 1'b1 && f_hsync === 1'b0) begin
        fall_at = c;
        n_checks++;
        if (f_x !== 10'd656) begin
          n_fail++;
          $display("FAIL hsync_fall_x: got %0d expected 656", f_x);
        end
      end
      if (prev_hs === 1'b0 && f_hsync === 1'b1 && fall_at >= 0) begin
        n_checks++;
        if (c - fall_at != 96 * DIV) begin
          n_fail++;
          $display("FAIL hsync_width: got %0d clk expected %0d clk", c - fall_at, 96 * DIV);
        end
      end
      if (prev_act === 1'b1 && f_active === 1'b0) begin
        n_checks++;
        if (f_x !== 10'd640) begin
          n_fail++;
          $display("FAIL active_fall_x: got %0d expected 640", f_x);
        end
      end
      if (f_ls === 1'b1) begin
        if (last_ls >= 0) begin
          n_checks++;
          if (c - last_ls != 800 * DIV) begin
            n_fail++;
            $display("FAIL line_period: got %0d clk expected %0d clk", c - last_ls, 800 * DIV);
          end
        end
        last_ls = c;
      end
      prev_hs  = f_hsync;
      prev_act = f_active;
    end
  endtask

  task automatic test_frame();
    int last_fs = -1, vs_low = 0, act_pix = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < (3 * S_FRAME + 20) * DIV; c++) begin
      tick();
      n_checks += 2;
      if (f_vec !== expect_vec(g_full)) begin
        n_fail++;
        $display("FAIL frame_full: got %h expected %h (steps %0d)", f_vec, expect_vec(g_full), steps);
      end
      if (s_vec !== expect_vec(g_small)) begin
        n_fail++;
        $display("FAIL frame_small: got %h expected %h (steps %0d)", s_vec, expect_vec(g_small), steps);
      end
      if (s_fs === 1'b1) begin
        if (last_fs >= 0) begin
          n_checks += 3;
          if (c - last_fs != S_FRAME * DIV) begin
            n_fail++;
            $display("FAIL frame_period: got %0d clk expected %0d clk", c - last_fs, S_FRAME * DIV);
          end
          if (vs_low != 3 * 35 * DIV) begin
            n_fail++;
            $display("FAIL vsync_width: got %0d clk expected %0d clk", vs_low, 3 * 35 * DIV);
          end
          if (act_pix != 20 * 12) begin
            n_fail++;
            $display("FAIL active_steps: got %0d expected %0d", act_pix, 20 * 12);
          end
        end
        last_fs = c; vs_low = 0; act_pix = 0;
      end
      if (s_vsync === 1'b0) vs_low++;
      if (s_pix === 1'b1 && s_active === 1'b1) act_pix++;
    end
  endtask

  task automatic test_mid_reset();
    for (int it = 0; it < 4; it++) begin
      int run = $urandom_range(20, 1500);
      int ls_n = 0, fs_n = 0;
      for (int c = 0; c < run; c++) begin
        tick();
        n_checks += 2;
        if (f_vec !== expect_vec(g_full)) begin
          n_fail++;
          $display("FAIL midrun_full: got %h expected %h (steps %0d)", f_vec, expect_vec(g_full), steps);
        end
        if (s_vec !== expect_vec(g_small)) begin
          n_fail++;
          $display("FAIL midrun_small: got %h expected %h (steps %0d)", s_vec, expect_vec(g_small), steps);
        end
      end
      rst = 1'b1;
      tick();
      n_checks += 3;
      if ({f_x, f_y, f_hsync} !== {10'd799, 10'd524, 1'b1}) begin
        n_fail++;
        $display("FAIL midreset_full: got x=%0d y=%0d hsync=%b expected x=799 y=524 hsync=1", f_x, f_y, f_hsync);
      end
      if ({s_x, s_y} !== {10'd34, 10'd18}) begin
        n_fail++;
        $display("FAIL midreset_small: got x=%0d y=%0d expected x=34 y=18", s_x, s_y);
      end
      if (f_vec !== expect_vec(g_full)) begin
        n_fail++;
        $display("FAIL midreset_vec: got %h expected %h", f_vec, expect_vec(g_full));
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
        tick();
        n_checks++;
        if (f_vec !== expect_vec(g_full)) begin
          n_fail++;
          $display("FAIL restart_full: got %h expected %h", f_vec, expect_vec(g_full));
        end
        if (f_ls === 1'b1) ls_n++;
        if (f_fs === 1'b1) fs_n++;
      end
      n_checks += 2;
      if (ls_n != 1) begin
        n_fail++;
        $display("FAIL restart_line_starts: got %0d expected 1", ls_n);
      end
      if (fs_n != 1) begin
        n_fail++;
        $display("FAIL restart_frame_starts: got %0d expected 1", fs_n);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 9) == 0);
      tick();
      n_checks += 2;
      if (f_vec !== expect_vec(g_full)) begin
        n_fail++;
        $display("FAIL b2b_full: got %h expected %h (cycle %0d)", f_vec, expect_vec(g_full), c);
      end
      if (s_vec !== expect_vec(g_small)) begin
        n_fail++;
        $display("FAIL b2b_small: got %h expected %h (cycle %0d)", s_vec, expect_vec(g_small), c);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_release();
    test_line();
    test_frame();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Pixel/raster timing generator for the Pac-Man VGA display path. It produces the pixel-clock enable, horizontal/vertical counters, active-video flag and sync pulses for 640x480 at 60 Hz. It sits directly upstream of the top-level VGA output (`hsync`, `vsync`, 2-bit `r`/`g`/`b`): the sync pins are driven from this block, and the pixel/sprite renderers use `x`, `y`, `active` and `pix_en` to produce colour.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `pix_en`  out  1  pixel-clock enable; one pixel step per high cycle
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `active`  out  1  high when (`x`,`y`) is in the visible area
- `x`  out  10  horizontal count, 0..H_TOTAL-1
- `y`  out  10  vertical count, 0..V_TOTAL-1
- `line_start`  out  1  one-`clk` pulse when `x` becomes 0
- `frame_start`  out  1  one-`clk` pulse when (`x`,`y`) becomes (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024; the counters are 10 bits wide.
- The horizontal counter `x` advances on each `clk` edge where `pix_en` is 1.
  - At H_TOTAL-1 it wraps to 0, and `y` increments.
  - When `y` is at V_TOTAL-1 and `x` wraps, `y` also wraps to 0.
- `hsync`, `vsync`, `active`, `line_start` and `frame_start` are registers. Each is loaded with the decode of the next counter value, so it changes on the same edge as `x`/`y`.
  - `hsync` = 0 when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vsync` = 0 when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491).
  - `active` = (x < H_ACTIVE) && (y < V_ACTIVE).
- `line_start` and `frame_start` are 1 for exactly one `clk` cycle after the edge that loads `x`=0 (respectively `x`=0,`y`=0). They are not held for the full pixel period.
- `x` and `y` are raw counter values and are meaningful outside the active area.
- Reset loads (`x`,`y`) = (H_TOTAL-1, V_TOTAL-1). The first step after reset therefore lands on (0,0) and emits `frame_start`.

## Timing
- Reset values (while `rst`=1 and after the reset edge):
  - `x`=799, `y`=524
  - `hsync`=1, `vsync`=1, `active`=0
  - `line_start`=0, `frame_start`=0
  - `pix_en`=0
- `rst` is checked before everything else: asserting it mid-frame returns all state to the reset values on the next edge, with no partial line.
- `pix_en` is a register. Counter and output updates take effect on the edge where `pix_en` is sampled as 1, so outputs change one `clk` after the `pix_en` high cycle.
- Downstream stages must register colour on `pix_en` using the `x`/`y`/`active` values present in that same cycle.
- Latency from `rst` falling to `frame_start`: see Configuration.

## Configuration
- Macro: `VGA_PIX_DIV_EN`.
- Defined (50 MHz board clock):
  - `pix_en` toggles every `clk`, starting at 1 on the first edge with `rst`=0.
  - Pixel rate is `clk`/2, one step per 2 `clk`.
  - `frame_start` is asserted 2 `clk` after `rst` deasserts.
- Undefined (`clk` already 25 MHz):
  - `pix_en` is 1 on every edge with `rst`=0.
  - Pixel rate equals `clk`.
  - `frame_start` is asserted 2 `clk` after `rst` deasserts: one edge to set `pix_en`, one to step.

## Test plan
- Reset: hold `rst` for 5 `clk` -> `x`=799, `y`=524, `hsync`=1, `vsync`=1, `active`=0, `pix_en`=0, `line_start`=0, `frame_start`=0.
- Release reset (`VGA_PIX_DIV_EN` defined) -> `pix_en` sequence 1,0,1,0…; `x`=0, `y`=0, `active`=1, `frame_start`=1 for exactly 1 `clk`; `x`=1 two `clk` later.
- Horizontal line -> `hsync` falls when `x`=656 and stays low 96 pixel steps (192 `clk` with the divider); `active` falls at `x`=640; `line_start` pulses once per 800 steps.
- Full frame -> `vsync` low for `y`=490..491 (1600 steps); `frame_start` pulses repeat every 420000 pixel steps (840000 `clk` with the divider); exactly 307200 steps have `active`=1 per frame.
- Reset mid-frame at `x`=300, `y`=200 -> next edge gives `x`=799, `y`=524, `hsync`=1; the restart emits `frame_start` with no extra `line_start`.
- Build without `VGA_PIX_DIV_EN` -> `pix_en` stays 1 continuously; one line takes 800 `clk`; sync positions are unchanged.
